fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
- Shares the single framebuffer RGB port (17-bit address, 8-bit data, 1-cycle synchronous read) between two requesters.
- Requester 0 is the SPI GPU command path. Requester 1 is a local engine such as a fill/clear/blit unit.
- Uses burst-limited round-robin arbitration, with a registered output stage toward the framebuffer and tagged read-data return.
- Sits in the clk_pixel domain, between the requesters and the framebuffer rgb_* port.

Parameters:
ADDR_W, 17, framebuffer RGB address width
DATA_W, 8, pixel index width
BURST_MAX, 16, max consecutive grants to one requester while the other is waiting (range 1..255)

Ports:
clk_pixel  in  1  pixel clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
s0_valid  in  1  requester 0 has a command
s0_ready  out  1  requester 0 command accepted this cycle
s0_we  in  1  1 = write, 0 = read
s0_addr  in  ADDR_W  pixel address
s0_wdata  in  DATA_W  write data
s0_rvalid  out  1  read data valid for requester 0
s0_rdata  out  DATA_W  read data
s1_valid, s1_ready, s1_we, s1_addr, s1_wdata, s1_rvalid, s1_rdata  same as s0_*, for requester 1
fb_addr  out  ADDR_W  to framebuffer rgb_addr
fb_wdata  out  DATA_W  to framebuffer rgb_in
fb_wren  out  1  to framebuffer wren_rgb
fb_rdata  in  DATA_W  from framebuffer rgb_out; valid 1 cycle after address is presented
vblank  in  1  framebuffer vblank flag, clk_pixel domain
busy  out  1  a command is issued or a read is in flight

Behaviour:
- Reset values: all outputs 0. Internal state: last_owner = 1 (so requester 0 wins the first tie), burst_cnt = 0, pipeline tags cleared.
- Handshake:
  - sN_ready is combinational, asserted only in the cycle sN is granted.
  - A transfer occurs when sN_valid && sN_ready.
  - The requester must hold valid, we, addr and wdata stable until accepted.
- Grant rules, evaluated every cycle, at most one grant per cycle:
  - Only one requester valid: grant it.
  - Both valid, and the current owner has burst_cnt < BURST_MAX: grant the owner.
  - Otherwise grant the non-owner.
- Burst counter:
  - On grant to the same owner, burst_cnt increments, saturating at BURST_MAX.
  - On an owner change, burst_cnt = 1.
  - When no grant is given, burst_cnt holds.
- Issue stage (registered): on the accept cycle T, fb_addr/fb_wdata/fb_wren are loaded at edge T+1. fb_wren = we && granted.
- When no grant is given:
  - fb_wren = 0.
  - fb_addr holds its last value.
- Read path:
  - An accepted read at T places its address on fb_addr at T+1.
  - The framebuffer returns data at T+2.
  - sN_rdata is registered from fb_rdata, and sN_rvalid pulses for 1 cycle at T+3.
  - A 2-stage owner/read tag pipeline routes the returned data.
  - Only the addressed requester's rvalid asserts; the other rdata holds.
- Throughput: 1 command per cycle sustained, with no bubble on an owner switch.
- Read-after-write to the same address, issued back-to-back by either requester, returns the new data. Port order is preserved.
- busy = any issue-stage or tag-pipeline slot occupied.
- Reset mid-operation: in-flight reads are dropped, with no rvalid after reset. fb_wren deasserts immediately (asynchronous).

Optional Feature:
- Macro: FB_ARB_VBLANK_GATE_EN.
- When defined: requester 1 is only eligible while vblank = 1. s1 commands pending at the vblank falling edge stall (s1_ready = 0) until the next vblank. Requester 0 is unaffected. A command already accepted completes normally.
- When undefined: the vblank port is present but ignored, and requester 1 is always eligible.

Decomposition:
- Shared package fb_pkg:
  - FB_ADDR_W = 17
  - FB_DATA_W = 8
  - FB_READ_LATENCY = 1
  - typedef fb_req_t {we, addr, wdata}
  - typedef enum owner_t {OWNER_S0, OWNER_S1}
- Sub-module rr_burst_grant: pure grant/burst-counter logic. Inputs: valid pair, eligibility pair. Outputs: one-hot grant, owner. Reusable for palette-port arbitration later.

Test Plan:
- Reset release, s0 only: 4 writes to addr 0x00010..0x00013, data 0xA0..0xA3 -> s0_ready high each cycle. fb_wren high T+1..T+4 with matching addr/data. s1_ready stays 0.
- Both continuously valid, BURST_MAX = 4 -> grant pattern s0×4, s1×4, s0×4. No idle cycle at any switch. Each requester's own addresses appear in order.
- s0 writes 0x55 to 0x1FFFF, then s1 reads 0x1FFFF next cycle -> s1_rvalid 3 cycles after s1 accept with s1_rdata = 0x55. s0_rvalid never asserts.
- Interleaved reads s0@0x00100, s1@0x00200, s0@0x00300 on consecutive cycles (framebuffer model preloaded) -> rvalids on consecutive cycles, each routed to the correct requester with the correct data.
- Reset asserted 1 cycle after a read is accepted -> all outputs 0 immediately. No rvalid afterwards. After release, first tie goes to s0.
- With FB_ARB_VBLANK_GATE_EN, s1 valid and vblank = 0 for 100 cycles -> s1_ready stays 0. vblank rises -> s1 granted in the same cycle, with s0 idle.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer port definitions for the RGB-port arbiter and future port users.
package fb_pkg;

   localparam int FB_ADDR_W       = 17;
   localparam int FB_DATA_W       = 8;
   localparam int FB_READ_LATENCY = 1;

   typedef struct packed {
      logic                 we;
      logic [FB_ADDR_W-1:0] addr;
      logic [FB_DATA_W-1:0] wdata;
   } fb_req_t;

   typedef enum logic {
      OWNER_S0 = 1'b0,
      OWNER_S1 = 1'b1
   } owner_t;

endpackage

// File: rtl/fb_write_arbiter_rr_burst_grant.sv
// Two-way burst-limited round-robin grant; no datapath, so it can be reused for other
// shared ports.
module rr_burst_grant
   import fb_pkg::*;
#(
   parameter int BURST_MAX = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] valid_i,
   input  logic [1:0] elig_i,
   output logic [1:0] grant_o,
   output owner_t     owner_o
);

   localparam logic [7:0] BMAX = 8'(BURST_MAX);

   owner_t     owner_q, owner_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] req;
   logic       hold;
   owner_t     gnt_own;

   // A zero count means no burst is running, so the out-of-reset owner (s1) yields the tie.
   always_comb begin
      req     = valid_i & elig_i;
      hold    = (cnt_q != 8'd0) && (cnt_q < BMAX);
      grant_o = 2'b00;
      unique case (req)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11: begin
            if (hold) grant_o = (owner_q == OWNER_S0) ? 2'b01 : 2'b10;
            else      grant_o = (owner_q == OWNER_S0) ? 2'b10 : 2'b01;
         end
         default: grant_o = 2'b00;
      endcase
   end

   always_comb begin
      owner_d = owner_q;
      cnt_d   = cnt_q;
      gnt_own = grant_o[1] ? OWNER_S1 : OWNER_S0;
      if (|grant_o) begin
         if (gnt_own == owner_q) begin
            cnt_d = (cnt_q >= BMAX) ? BMAX : cnt_q + 8'd1;
         end else begin
            owner_d = gnt_own;
            cnt_d   = 8'd1;
         end
      end
   end

   assign owner_o = owner_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         owner_q <= OWNER_S1;
         cnt_q   <= 8'd0;
      end else begin
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the framebuffer RGB port between the SPI command path (s0) and a local engine (s1).
// Define FB_ARB_VBLANK_GATE_EN to let s1 win the port only while vblank is high.
module fb_write_arbiter
   import fb_pkg::*;
#(
   parameter int ADDR_W    = FB_ADDR_W,
   parameter int DATA_W    = FB_DATA_W,
   parameter int BURST_MAX = 16
) (
   input  logic              clk_pixel,
   input  logic              reset,
   input  logic              s0_valid,
   output logic              s0_ready,
   input  logic              s0_we,
   input  logic [ADDR_W-1:0] s0_addr,
   input  logic [DATA_W-1:0] s0_wdata,
   output logic              s0_rvalid,
   output logic [DATA_W-1:0] s0_rdata,
   input  logic              s1_valid,
   output logic              s1_ready,
   input  logic              s1_we,
   input  logic [ADDR_W-1:0] s1_addr,
   input  logic [DATA_W-1:0] s1_wdata,
   output logic              s1_rvalid,
   output logic [DATA_W-1:0] s1_rdata,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [DATA_W-1:0] fb_wdata,
   output logic              fb_wren,
   input  logic [DATA_W-1:0] fb_rdata,
   input  logic              vblank,
   output logic              busy
);

   localparam int STAGES = FB_READ_LATENCY + 1;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   logic [1:0]        valid, elig, grant;
   owner_t            owner;
   req_t              req_s0, req_s1, req_sel;
   logic              acc, rd_acc, own_s1;

   logic [ADDR_W-1:0] fb_addr_q;
   logic [DATA_W-1:0] fb_wdata_q;
   logic              fb_wren_q, iss_vld_q;
   logic [STAGES:1]   rd_vld_q, rd_own_q;
   logic              s0_rvalid_q, s1_rvalid_q;
   logic [DATA_W-1:0] s0_rdata_q, s1_rdata_q;

   assign valid = {s1_valid, s0_valid};

   // Readies must read 0 while reset is held, so eligibility drops with it.
`ifdef FB_ARB_VBLANK_GATE_EN
   assign elig = {vblank & ~reset, ~reset};
`else
   logic unused_vblank;
   assign unused_vblank = vblank;
   assign elig = {~reset, ~reset};
`endif

   rr_burst_grant #(.BURST_MAX(BURST_MAX)) u_grant (
      .clk_i   (clk_pixel),
      .rst_i   (reset),
      .valid_i (valid),
      .elig_i  (elig),
      .grant_o (grant),
      .owner_o (owner)
   );

   assign s0_ready = grant[0];
   assign s1_ready = grant[1];

   assign req_s0  = {s0_we, s0_addr, s0_wdata};
   assign req_s1  = {s1_we, s1_addr, s1_wdata};
   assign req_sel = grant[1] ? req_s1 : req_s0;
   assign acc     = |grant;
   assign rd_acc  = acc & ~req_sel.we;
   assign own_s1  = (owner == OWNER_S1);

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         fb_addr_q  <= '0;
         fb_wdata_q <= '0;
         fb_wren_q  <= 1'b0;
         iss_vld_q  <= 1'b0;
      end else begin
         iss_vld_q <= acc;
         fb_wren_q <= acc & req_sel.we;
         if (acc) begin
            fb_addr_q  <= req_sel.addr;
            fb_wdata_q <= req_sel.wdata;
         end
      end
   end

   // Read tag pipeline: stage 1 aligns with the issued address, stage STAGES with fb_rdata.
   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         rd_vld_q    <= '0;
         rd_own_q    <= '0;
         s0_rvalid_q <= 1'b0;
         s1_rvalid_q <= 1'b0;
         s0_rdata_q  <= '0;
         s1_rdata_q  <= '0;
      end else begin
         rd_vld_q    <= {rd_vld_q[STAGES-1:1], rd_acc};
         rd_own_q    <= {rd_own_q[STAGES-1:1], own_s1};
         s0_rvalid_q <= rd_vld_q[STAGES] & ~rd_own_q[STAGES];
         s1_rvalid_q <= rd_vld_q[STAGES] &  rd_own_q[STAGES];
         if (rd_vld_q[STAGES] & ~rd_own_q[STAGES]) s0_rdata_q <= fb_rdata;
         if (rd_vld_q[STAGES] &  rd_own_q[STAGES]) s1_rdata_q <= fb_rdata;
      end
   end

   assign fb_addr   = fb_addr_q;
   assign fb_wdata  = fb_wdata_q;
   assign fb_wren   = fb_wren_q;
   assign s0_rvalid = s0_rvalid_q;
   assign s1_rvalid = s1_rvalid_q;
   assign s0_rdata  = s0_rdata_q;
   assign s1_rdata  = s1_rdata_q;
   assign busy      = iss_vld_q | (|rd_vld_q);

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter with a read-first synchronous framebuffer model.
module tb_fb_write_arbiter;

   localparam int AW = 17;
   localparam int DW = 8;

   logic          clk_pixel = 1'b0;
   logic          reset = 1'b1;
   logic          s0_valid = 0, s0_we = 0, s1_valid = 0, s1_we = 0;
   logic [AW-1:0] s0_addr = '0, s1_addr = '0;
   logic [DW-1:0] s0_wdata = '0, s1_wdata = '0;
   logic          s0_ready, s1_ready, s0_rvalid, s1_rvalid;
   logic [DW-1:0] s0_rdata, s1_rdata;
   logic [AW-1:0] fb_addr;
   logic [DW-1:0] fb_wdata, fb_rdata;
   logic          fb_wren, busy;
   logic          vblank = 1'b0;

   always #5 clk_pixel = ~clk_pixel;

   fb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(4)) dut (
      .clk_pixel(clk_pixel), .reset(reset),
      .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_we(s0_we), .s0_addr(s0_addr),
      .s0_wdata(s0_wdata), .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata),
      .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_we(s1_we), .s1_addr(s1_addr),
      .s1_wdata(s1_wdata), .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata),
      .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_wren(fb_wren), .fb_rdata(fb_rdata),
      .vblank(vblank), .busy(busy)
   );

   // Framebuffer model: 1-cycle synchronous read, read-before-write on the same edge.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [DW-1:0] pl_data = '0;
   always @(posedge clk_pixel) begin
      if (pl_en)        mem[pl_addr] <= pl_data;
      else if (fb_wren) mem[fb_addr] <= fb_wdata;
      fb_rdata <= mem[fb_addr];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic          s0v, s0we;
      logic [AW-1:0] s0a;
      logic [DW-1:0] s0d;
      logic          s1v, s1we;
      logic [AW-1:0] s1a;
      logic [DW-1:0] s1d;
      logic          r0, r1, wren;
      logic [AW-1:0] fa;
      logic [DW-1:0] fd;
   } vec_t;
   vec_t tv[$];

   task automatic push(input logic s0v, input logic s0we, input logic [AW-1:0] s0a,
                       input logic [DW-1:0] s0d, input logic s1v, input logic s1we,
                       input logic [AW-1:0] s1a, input logic [DW-1:0] s1d,
                       input logic r0, input logic r1, input logic wren,
                       input logic [AW-1:0] fa, input logic [DW-1:0] fd);
      vec_t v;
      v.s0v = s0v; v.s0we = s0we; v.s0a = s0a; v.s0d = s0d;
      v.s1v = s1v; v.s1we = s1we; v.s1a = s1a; v.s1d = s1d;
      v.r0 = r0; v.r1 = r1; v.wren = wren; v.fa = fa; v.fd = fd;
      tv.push_back(v);
   endtask

   // Each vector is held for one cycle; fb_* expectations reflect the previous vector's accept.
   task automatic run_tv(input string tag);
      for (int i = 0; i < tv.size(); i++) begin
         @(posedge clk_pixel); #1;
         s0_valid = tv[i].s0v; s0_we = tv[i].s0we; s0_addr = tv[i].s0a; s0_wdata = tv[i].s0d;
         s1_valid = tv[i].s1v; s1_we = tv[i].s1we; s1_addr = tv[i].s1a; s1_wdata = tv[i].s1d;
         @(negedge clk_pixel);
         chk($sformatf("%s[%0d].s0_ready", tag, i), s0_ready, tv[i].r0);
         chk($sformatf("%s[%0d].s1_ready", tag, i), s1_ready, tv[i].r1);
         chk($sformatf("%s[%0d].fb_wren", tag, i), fb_wren, tv[i].wren);
         chk($sformatf("%s[%0d].fb_addr", tag, i), fb_addr, tv[i].fa);
         chk($sformatf("%s[%0d].fb_wdata", tag, i), fb_wdata, tv[i].fd);
         chk($sformatf("%s[%0d].rvalid", tag, i), {s1_rvalid, s0_rvalid}, 0);
      end
      tv.delete();
   endtask

   task automatic idle_inputs();
      s0_valid = 0; s0_we = 0; s1_valid = 0; s1_we = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".ready"}, {s1_ready, s0_ready}, 0);
      chk({tag, ".rvalid"}, {s1_rvalid, s0_rvalid}, 0);
      chk({tag, ".rdata"}, {s1_rdata, s0_rdata}, 0);
      chk({tag, ".fb_addr"}, fb_addr, 0);
      chk({tag, ".fb_wdata"}, fb_wdata, 0);
      chk({tag, ".fb_wren_busy"}, {fb_wren, busy}, 0);
   endtask

   task automatic do_reset();
      @(posedge clk_pixel); #1;
      idle_inputs();
      reset = 1'b1;
      #1 chk_all_zero("reset");
      @(posedge clk_pixel); #1;
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] pa;
      logic [DW-1:0] pd;
      logic          pw;
      int            i0, i1, g;

      #2 chk_all_zero("por");
      @(posedge clk_pixel); #1;
      reset = 1'b0;

      // s0 alone: four back-to-back writes, then drain
      push(1, 1, 17'h00010, 8'hA0, 0, 0, '0, '0, 1, 0, 0, 17'h00000, 8'h00);
      push(1, 1, 17'h00011, 8'hA1, 0, 0, '0, '0, 1, 0, 1, 17'h00010, 8'hA0);
      push(1, 1, 17'h00012, 8'hA2, 0, 0, '0, '0, 1, 0, 1, 17'h00011, 8'hA1);
      push(1, 1, 17'h00013, 8'hA3, 0, 0, '0, '0, 1, 0, 1, 17'h00012, 8'hA2);
      push(0, 0, 17'h00000, 8'h00, 0, 0, '0, '0, 0, 0, 1, 17'h00013, 8'hA3);
      push(0, 0, 17'h00000, 8'h00, 0, 0, '0, '0, 0, 0, 0, 17'h00013, 8'hA3);
      run_tv("s0only");

      // Both saturated with BURST_MAX=4: s0 x4, s1 x4, s0 x4, each address stream in order
      do_reset();
      i0 = 0; i1 = 0; pw = 0; pa = '0; pd = '0;
      for (int k = 0; k < 12; k++) begin
         g = (k / 4) % 2;
         push(1, 1, AW'(17'h00100 + i0), DW'(8'h10 + i0), 1, 1, AW'(17'h00200 + i1),
              DW'(8'h20 + i1), g == 0, g == 1, pw, pa, pd);
         pw = 1;
         if (g == 1) begin
            pa = AW'(17'h00200 + i1); pd = DW'(8'h20 + i1); i1++;
         end else begin
            pa = AW'(17'h00100 + i0); pd = DW'(8'h10 + i0); i0++;
         end
      end
      push(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, pw, pa, pd);
      run_tv("burst");

      // Read-after-write across requesters on the top address
      @(posedge clk_pixel); #1;
      s0_valid = 1; s0_we = 1; s0_addr = 17'h1FFFF; s0_wdata = 8'h55;
      @(negedge clk_pixel);
      chk("raw.s0_ready", s0_ready, 1);
      @(posedge clk_pixel); #1;
      idle_inputs();
      s1_valid = 1; s1_we = 0; s1_addr = 17'h1FFFF;
      @(negedge clk_pixel);
      chk("raw.s1_ready", {s1_ready, s0_ready}, 2'b10);
      chk("raw.wr_issue", {fb_wren, fb_addr, fb_wdata}, {1'b1, 17'h1FFFF, 8'h55});
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk_pixel); #1;
         idle_inputs();
         @(negedge clk_pixel);
         chk($sformatf("raw.c%0d.s1_rvalid", c), s1_rvalid, c == 3);
         chk($sformatf("raw.c%0d.s0_rvalid", c), s0_rvalid, 0);
         if (c == 1) chk("raw.rd_issue", {fb_wren, fb_addr}, {1'b0, 17'h1FFFF});
         if (c == 3) chk("raw.s1_rdata", s1_rdata, 8'h55);
      end

      // Preload, then interleaved single-requester reads on consecutive cycles
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk_pixel); #1;
         pl_en = 1; pl_addr = AW'(k * 32'h100); pl_data = DW'(k * 8'h11);
      end
      @(posedge clk_pixel); #1;
      pl_en = 0;
      for (int c = 0; c < 7; c++) begin
         @(posedge clk_pixel); #1;
         idle_inputs();
         s0_valid = (c == 0 || c == 2);
         s0_addr  = (c == 0) ? 17'h00100 : 17'h00300;
         s1_valid = (c == 1);
         s1_addr  = 17'h00200;
         @(negedge clk_pixel);
         chk($sformatf("ilv.c%0d.ready", c), {s1_ready, s0_ready}, {c == 1, c == 0 || c == 2});
         chk($sformatf("ilv.c%0d.rvalid", c), {s1_rvalid, s0_rvalid}, {c == 4, c == 3 || c == 5});
         chk($sformatf("ilv.c%0d.busy", c), busy, c >= 1 && c <= 4);
         if (c == 3) chk("ilv.s0_rdata0", s0_rdata, 8'h11);
         if (c == 4) chk("ilv.s1_rdata", s1_rdata, 8'h22);
         if (c == 5) chk("ilv.rdata_hold", {s0_rdata, s1_rdata}, {8'h33, 8'h22});
      end

      // Reset one cycle after a read is accepted
      @(posedge clk_pixel); #1;
      s0_valid = 1; s0_we = 0; s0_addr = 17'h00100;
      @(negedge clk_pixel);
      chk("rstmid.s0_ready", s0_ready, 1);
      @(posedge clk_pixel); #1;
      idle_inputs();
      reset = 1'b1;
      #1 chk_all_zero("rstmid");
      repeat (2) @(posedge clk_pixel);
      #1 reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_pixel);
         chk($sformatf("rstmid.c%0d.quiet", c), {s1_rvalid, s0_rvalid, busy}, 0);
      end
      @(posedge clk_pixel); #1;
      s0_valid = 1; s0_we = 1; s0_addr = 17'h00001;
      s1_valid = 1; s1_we = 1; s1_addr = 17'h00002;
      @(negedge clk_pixel);
      chk("rstmid.first_tie", {s1_ready, s0_ready}, 2'b01);
      @(posedge clk_pixel); #1;
      idle_inputs();
      repeat (2) @(posedge clk_pixel);

      // vblank handling for requester 1
      #1 s1_valid = 1; s1_we = 1; s1_addr = 17'h00400; s1_wdata = 8'h77; vblank = 0;
`ifdef FB_ARB_VBLANK_GATE_EN
      for (int c = 0; c < 100; c++) begin
         @(negedge clk_pixel);
         chk($sformatf("vb.c%0d.s1_blocked", c), s1_ready, 0);
         @(posedge clk_pixel); #1;
      end
      vblank = 1;
      @(negedge clk_pixel);
      chk("vb.rise_grant", {s1_ready, s0_ready}, 2'b10);
`else
      @(negedge clk_pixel);
      chk("vb.ignored", {s1_ready, s0_ready}, 2'b10);
`endif
      @(posedge clk_pixel); #1;
      idle_inputs();
      vblank = 0;
      @(negedge clk_pixel);
      chk("vb.issue", {fb_wren, fb_addr, fb_wdata}, {1'b1, 17'h00400, 8'h77});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
